// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave: debounced switch inputs, LED outputs with atomic set/clear, edge IRQs onto FABINT.
// Zero wait states; PRDATA combinational in access phase; FABINT one edge behind IRQ_STATUS.
module apb_gpio_irq #(
    parameter int                 NUM_IN          = 2,
    parameter int                 NUM_OUT         = 8,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_OUT-1:0] OUT_RESET       = '0
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [8:0]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [NUM_IN-1:0]  SW_IN,
    output logic [NUM_OUT-1:0] LED_OUT,
    output logic               FABINT
);

    logic [NUM_IN-1:0]  sync1_q, sync2_q, din_w, din_prev_q;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [NUM_IN-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NUM_IN-1:0]  status_q, status_d, w1c, set_ev;
    logic               fabint_q;
    logic [2:0]         idx;
    logic               access, addr_ok, err, wr_en;
    logic [31:0]        rdata;
    logic               unused_ok;

    assign unused_ok = ^{PADDR[1:0], PWDATA};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic db_q;
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) db_q <= 1'b0;
                else        db_q <= sync2_q[i];
            end
            assign din_w[i] = db_q;
        end else begin : g_deb
            logic        db_q, db_d;
            logic [15:0] cnt_q, cnt_d;
            // A change is accepted only after it has persisted DEBOUNCE_CYCLES cycles past the first mismatch.
            always_comb begin
                cnt_d = '0;
                db_d  = db_q;
                if (sync2_q[i] != db_q) begin
                    if (cnt_q == 16'(DEBOUNCE_CYCLES)) db_d  = sync2_q[i];
                    else                               cnt_d = cnt_q + 16'd1;
                end
            end
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    db_q  <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    db_q  <= db_d;
                    cnt_q <= cnt_d;
                end
            end
            assign din_w[i] = db_q;
        end
    end

    assign access  = PSEL & PENABLE;
    assign idx     = PADDR[4:2];
    assign addr_ok = (PADDR[8:5] == 4'd0);
    assign err     = access & (~addr_ok
                             | (~PWRITE & ((idx == 3'd2) | (idx == 3'd3)))
                             | ( PWRITE & ((idx == 3'd0) | (idx == 3'd7))));
    assign wr_en   = access & PWRITE & ~err;

    assign set_ev = (din_w & ~din_prev_q & rise_en_q) | (~din_w & din_prev_q & fall_en_q);

    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_en) begin
            case (idx)
                3'd1:    out_d     = PWDATA[NUM_OUT-1:0];
                3'd2:    out_d     = out_q | PWDATA[NUM_OUT-1:0];
                3'd3:    out_d     = out_q & ~PWDATA[NUM_OUT-1:0];
                3'd4:    rise_en_d = PWDATA[NUM_IN-1:0];
                3'd5:    fall_en_d = PWDATA[NUM_IN-1:0];
                3'd6:    w1c       = PWDATA[NUM_IN-1:0];
                default: ;
            endcase
        end
        // A new edge event in the same cycle as its W1C keeps the bit pending.
        status_d = (status_q & ~w1c) | set_ev;
    end

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = 32'(din_w);
            3'd1:    rdata = 32'(out_q);
            3'd4:    rdata = 32'(rise_en_q);
            3'd5:    rdata = 32'(fall_en_q);
            3'd6:    rdata = 32'(status_q);
            3'd7:    rdata = {16'(DEBOUNCE_CYCLES), 8'(NUM_OUT), 8'(NUM_IN)};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            din_prev_q <= '0;
            out_q      <= OUT_RESET;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            fabint_q   <= 1'b0;
        end else begin
            sync1_q    <= SW_IN;
            sync2_q    <= sync1_q;
            din_prev_q <= din_w;
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            fabint_q   <= |status_q;
        end
    end

    assign PRDATA  = (access & ~err) ? rdata : 32'd0;
    assign PREADY  = 1'b1;
    assign PSLVERR = err;
    assign LED_OUT = out_q;
    assign FABINT  = fabint_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Bench for apb_gpio_irq: expected values queued when stimulus is driven, popped when the DUT answers.
module tb_apb_gpio_irq;
    localparam logic [7:0] LED_RST = 8'h3C;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [8:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [1:0]  SW_IN;
    logic [7:0]  LED_OUT;
    logic        FABINT;

    int          n_checks = 0;
    int          n_errors = 0;
    string       sb_tag[$];
    logic [31:0] sb_val[$];
    logic [7:0]  led_m;

    apb_gpio_irq #(.NUM_IN(2), .NUM_OUT(8), .DEBOUNCE_CYCLES(16), .OUT_RESET(LED_RST)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .SW_IN(SW_IN), .LED_OUT(LED_OUT), .FABINT(FABINT)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        if (sb_val.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_underflow: got 0x%08h expected no output", got);
        end else begin
            t = sb_tag.pop_front();
            e = sb_val.pop_front();
            check(t, got, e);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access (commit) edge.
    task automatic apb(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd_o, output logic err_o, output logic rdy_o);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        rd_o = PRDATA; err_o = PSLVERR; rdy_o = PREADY;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [8:0] a, input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e, r;
        sb_push(tag, exp_d);
        sb_push({tag, "_slverr"}, 32'(exp_e));
        apb(1'b0, a, 32'd0, d, e, r);
        sb_pop(d);
        sb_pop(32'(e));
        check({tag, "_pready"}, 32'(r), 32'd1);
    endtask

    task automatic wr_chk(input string tag, input logic [8:0] a, input logic [31:0] wd, input logic exp_e);
        logic [31:0] d;
        logic        e, r;
        sb_push({tag, "_slverr"}, 32'(exp_e));
        sb_push({tag, "_led"}, 32'(led_m));
        apb(1'b1, a, wd, d, e, r);
        sb_pop(32'(e));
        sb_pop(32'(LED_OUT));
        check({tag, "_pready"}, 32'(r), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; SW_IN = 2'b00;
        led_m = LED_RST;
        cycles(3);
        check("rst_led", 32'(LED_OUT), 32'(LED_RST));
        check("rst_fabint", 32'(FABINT), 32'd0);
        PRESET = 1'b0;
        cycles(1);

        // Reset register values
        rd_chk("rst_din",    9'h00, 32'd0, 1'b0);
        rd_chk("rst_dout",   9'h04, 32'(LED_RST), 1'b0);
        rd_chk("rst_set",    9'h08, 32'd0, 1'b1);
        rd_chk("rst_clr",    9'h0C, 32'd0, 1'b1);
        rd_chk("rst_rise",   9'h10, 32'd0, 1'b0);
        rd_chk("rst_fall",   9'h14, 32'd0, 1'b0);
        rd_chk("rst_status", 9'h18, 32'd0, 1'b0);
        rd_chk("info",       9'h1C, 32'h0010_0802, 1'b0);

        // LED write / set / clear
        led_m = 8'hA5; wr_chk("led_wr",  9'h04, 32'h0000_00A5, 1'b0);
        led_m = 8'hAF; wr_chk("led_set", 9'h08, 32'h0000_000F, 1'b0);
        led_m = 8'h2E; wr_chk("led_clr", 9'h0C, 32'h0000_0081, 1'b0);
        rd_chk("led_rb", 9'h04, 32'h0000_002E, 1'b0);

        // Error accesses leave state alone
        rd_chk("err_rd20",  9'h20, 32'd0, 1'b1);
        wr_chk("err_wr00",  9'h00, 32'hFFFF_FFFF, 1'b0 | 1'b1);
        rd_chk("err_rd08",  9'h08, 32'd0, 1'b1);
        wr_chk("err_wr104", 9'h104, 32'h0000_0055, 1'b1);
        wr_chk("err_wr1c",  9'h1C, 32'h0000_0000, 1'b1);
        rd_chk("err_led_rb", 9'h04, 32'h0000_002E, 1'b0);
        rd_chk("err_din_rb", 9'h00, 32'd0, 1'b0);

        // Bring SW_IN[1] high before any enable: no status expected
        SW_IN[1] = 1'b1;
        cycles(40);
        rd_chk("sw1_din", 9'h00, 32'h2, 1'b0);
        wr_chk("rise_en", 9'h10, 32'h1, 1'b0);
        wr_chk("fall_en", 9'h14, 32'h2, 1'b0);
        rd_chk("pre_status", 9'h18, 32'd0, 1'b0);

        // Glitch shorter than the debounce window
        SW_IN[0] = 1'b1;
        cycles(10);
        SW_IN[0] = 1'b0;
        cycles(40);
        rd_chk("glitch_din", 9'h00, 32'h2, 1'b0);
        rd_chk("glitch_status", 9'h18, 32'd0, 1'b0);
        check("glitch_fabint", 32'(FABINT), 32'd0);

        // Held input: DATA_IN at edge 18, IRQ_STATUS at 19, FABINT at 20
        SW_IN[0] = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 9'h00;
        for (int k = 0; k <= 20; k++) begin
            @(posedge PCLK); #1;
            if (k == 17) begin sb_push("din_e17", 32'h2); sb_pop(PRDATA); end
            if (k == 18) begin sb_push("din_e18", 32'h3); sb_pop(PRDATA); end
            if (k == 19) begin sb_push("fabint_e19", 32'd0); sb_pop(32'(FABINT)); end
            if (k == 20) begin sb_push("fabint_e20", 32'd1); sb_pop(32'(FABINT)); end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        cycles(1);
        rd_chk("rise_status", 9'h18, 32'h1, 1'b0);

        // Falling edge on bit 1
        SW_IN[1] = 1'b0;
        cycles(30);
        rd_chk("both_status", 9'h18, 32'h3, 1'b0);
        rd_chk("both_din", 9'h00, 32'h1, 1'b0);
        check("both_fabint", 32'(FABINT), 32'd1);

        // Disabling an enable keeps pending bits
        wr_chk("rise_off", 9'h10, 32'h0, 1'b0);
        rd_chk("keep_status", 9'h18, 32'h3, 1'b0);

        // W1C
        wr_chk("w1c_1", 9'h18, 32'h1, 1'b0);
        rd_chk("w1c_1_status", 9'h18, 32'h2, 1'b0);
        check("w1c_1_fabint", 32'(FABINT), 32'd1);
        wr_chk("w1c_2", 9'h18, 32'h2, 1'b0);
        check("w1c_2_fabint_hold", 32'(FABINT), 32'd1);
        cycles(1);
        check("w1c_2_fabint_drop", 32'(FABINT), 32'd0);
        rd_chk("w1c_2_status", 9'h18, 32'd0, 1'b0);

        // W1C landing on the same edge as a new rise event on bit 1
        wr_chk("rise_en3", 9'h10, 32'h3, 1'b0);
        SW_IN[1] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge PCLK); #1;
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h18; PWDATA = 32'h2;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        cycles(1);
        rd_chk("coinc_status", 9'h18, 32'h2, 1'b0);
        check("coinc_fabint", 32'(FABINT), 32'd1);

        // Asynchronous reset mid-debounce with an IRQ pending
        SW_IN = 2'b00;
        cycles(6);
        #3;
        PRESET = 1'b1;
        #1;
        check("arst_fabint", 32'(FABINT), 32'd0);
        check("arst_led", 32'(LED_OUT), 32'(LED_RST));
        cycles(2);
        PRESET = 1'b0;
        led_m = LED_RST;
        cycles(1);
        rd_chk("arst_din", 9'h00, 32'd0, 1'b0);
        rd_chk("arst_status", 9'h18, 32'd0, 1'b0);
        rd_chk("arst_rise", 9'h10, 32'd0, 1'b0);
        rd_chk("arst_dout", 9'h04, 32'(LED_RST), 1'b0);

        if (sb_val.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_val.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
